// File: rtl/hwpe_stream_package.sv
// Shared types for HWPE stream source/sink engines, including the TCDM reader
// control/flag bundles and its lane address helper.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_CNT_WIDTH = 16;

  typedef enum logic [0:0] {
    STREAM_IDLE    = 1'b0,
    STREAM_WORKING = 1'b1
  } state_sourcesink_t;

  typedef struct packed {
    logic [31:0]                      base_addr;
    logic [15:0]                      stride;
    logic [HWPE_STREAM_CNT_WIDTH-1:0] trans_size;
    logic                             req_start;
  } ctrl_tcdm_reader_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_tcdm_reader_t;

  // Byte address of beat idx on a lane; wraps modulo 2^32, stride zero-extended.
  function automatic logic [31:0] tcdm_lane_addr(input logic [31:0] base,
                                                 input logic [31:0] idx,
                                                 input logic [15:0] stride,
                                                 input logic [31:0] lane);
    tcdm_lane_addr = base + idx * {16'h0000, stride} + (lane << 2);
  endfunction

endpackage

// File: rtl/hwpe_stream_fifo.sv
// Registered FIFO for HWPE streams: a pushed word is visible on data_o the
// following cycle. Storage is unreset; the pointers alone define validity.
module hwpe_stream_fifo_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic push_i,
  input logic full_i
);
  push_into_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_i));
endmodule

module hwpe_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        pop_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        cnt_q;
  logic                  push_s, pop_s;

  assign full_o  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_s && !pop_s)      cnt_q <= cnt_q + (PTR_W+1)'(1);
      else if (pop_s && !push_s) cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= data_i;
  end

  hwpe_stream_fifo_chk i_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_i),
    .full_i (full_o)
  );

endmodule

// File: rtl/hwpe_stream_tcdm_reader_lane.sv
// One TCDM load lane: issue counter, outstanding tracking, credit gate,
// address generation and the in-order response FIFO.
module hwpe_stream_tcdm_reader_lane
  import hwpe_stream_package::*;
#(
  parameter int unsigned LANE_IDX   = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 en_i,
  input  logic [31:0]          base_addr_i,
  input  logic [15:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] trans_size_i,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  input  logic                 tcdm_gnt_i,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  input  logic                 pop_i,
  output logic [31:0]          data_o,
  output logic                 empty_o
);
  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH) + 2;

  logic [CNT_WIDTH-1:0] issue_cnt_q;
  logic [CRD_W-2:0]     outst_q;
  logic [CRD_W-2:0]     fifo_cnt_s;
  logic                 full_s, credit_s, req_s, gnt_s, push_s;

  // Buffered plus in-flight words never exceed the FIFO depth, so a push can never overflow.
  assign credit_s   = (({1'b0, fifo_cnt_s} + {1'b0, outst_q}) < CRD_W'(FIFO_DEPTH)) & ~full_s;
  assign req_s      = en_i & (issue_cnt_q < trans_size_i) & credit_s;
  assign gnt_s      = req_s & tcdm_gnt_i;
  assign push_s     = tcdm_r_valid_i & (outst_q != '0);
  assign tcdm_req_o = req_s;
  assign tcdm_add_o = req_s ? tcdm_lane_addr(base_addr_i, 32'(issue_cnt_q), stride_i, 32'(LANE_IDX))
                            : 32'h0000_0000;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q <= '0;
      outst_q     <= '0;
    end else if (clear_i) begin
      issue_cnt_q <= '0;
      outst_q     <= '0;
    end else begin
      if (start_i)    issue_cnt_q <= '0;
      else if (gnt_s) issue_cnt_q <= issue_cnt_q + CNT_WIDTH'(1);
      if (gnt_s && !push_s)      outst_q <= outst_q + (CRD_W-1)'(1);
      else if (push_s && !gnt_s) outst_q <= outst_q - (CRD_W-1)'(1);
    end
  end

  hwpe_stream_fifo #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push_s),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop_i),
    .data_o  (data_o),
    .empty_o (empty_o),
    .full_o  (full_s),
    .count_o (fifo_cnt_s)
  );

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Streaming TCDM reader: loads trans_size beats over NB_TCDM_PORTS lanes and
// emits them as one wide HWPE stream, pulsing done after the last beat.
module hwpe_stream_tcdm_reader
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_TCDM_PORTS = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [31:0]                   base_addr_i,
  input  logic [15:0]                   stride_i,
  input  logic [CNT_WIDTH-1:0]          trans_size_i,
  output logic                          ready_start_o,
  output logic                          done_o,
  output logic [NB_TCDM_PORTS-1:0]      tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]      tcdm_gnt_i,
  output logic [NB_TCDM_PORTS*32-1:0]   tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]      tcdm_wen_o,
  output logic [NB_TCDM_PORTS*4-1:0]    tcdm_be_o,
  output logic [NB_TCDM_PORTS*32-1:0]   tcdm_data_o,
  input  logic [NB_TCDM_PORTS*32-1:0]   tcdm_r_data_i,
  input  logic [NB_TCDM_PORTS-1:0]      tcdm_r_valid_i,
  output logic                          stream_valid_o,
  input  logic                          stream_ready_i,
  output logic [NB_TCDM_PORTS*32-1:0]   stream_data_o,
  output logic [NB_TCDM_PORTS*4-1:0]    stream_strb_o
);
  state_sourcesink_t    state_q;
  logic [31:0]          base_q;
  logic [15:0]          stride_q;
  logic [CNT_WIDTH-1:0] size_q, beat_cnt_q;
  logic                 done_q;

  logic [NB_TCDM_PORTS-1:0] empty_s;
  logic                     en_s, start_s, hs_s, last_s;

  assign en_s           = (state_q == STREAM_WORKING);
  assign start_s        = ~en_s & start_i & ~clear_i;
  assign stream_valid_o = ~|empty_s;
  assign hs_s           = stream_valid_o & stream_ready_i;
  assign last_s         = hs_s & ((beat_cnt_q + CNT_WIDTH'(1)) == size_q);

  assign ready_start_o = ~en_s;
  assign done_o        = done_q;
  assign tcdm_wen_o    = {NB_TCDM_PORTS{1'b1}};
  assign tcdm_data_o   = '0;
  assign stream_strb_o = {(NB_TCDM_PORTS*4){1'b1}};

  for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : gen_lane
    assign tcdm_be_o[4*i +: 4] = {4{tcdm_req_o[i]}};

    hwpe_stream_tcdm_reader_lane #(
      .LANE_IDX   (i),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) i_lane (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .start_i        (start_s),
      .en_i           (en_s),
      .base_addr_i    (base_q),
      .stride_i       (stride_q),
      .trans_size_i   (size_q),
      .tcdm_req_o     (tcdm_req_o[i]),
      .tcdm_add_o     (tcdm_add_o[32*i +: 32]),
      .tcdm_gnt_i     (tcdm_gnt_i[i]),
      .tcdm_r_data_i  (tcdm_r_data_i[32*i +: 32]),
      .tcdm_r_valid_i (tcdm_r_valid_i[i]),
      .pop_i          (hs_s),
      .data_o         (stream_data_o[32*i +: 32]),
      .empty_o        (empty_s[i])
    );
  end

  // Transfer control: a zero-length start completes immediately without leaving IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= STREAM_IDLE;
      base_q     <= 32'h0000_0000;
      stride_q   <= 16'h0000;
      size_q     <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
    end else if (clear_i) begin
      state_q    <= STREAM_IDLE;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        STREAM_IDLE: begin
          if (start_i) begin
            base_q     <= base_addr_i;
            stride_q   <= stride_i;
            size_q     <= trans_size_i;
            beat_cnt_q <= '0;
            if (trans_size_i == '0) done_q  <= 1'b1;
            else                    state_q <= STREAM_WORKING;
          end
        end
        STREAM_WORKING: begin
          if (hs_s) begin
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            if (last_s) begin
              state_q <= STREAM_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= STREAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Bench for hwpe_stream_tcdm_reader: a transaction-level model (per-lane grant
// and arrival counts, consumed-beat count) predicts every output every cycle.
module tb_hwpe_stream_tcdm_reader;
  localparam int NB    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni, clear_i, start_i;
  logic [31:0]       base_addr_i;
  logic [15:0]       stride_i;
  logic [CW-1:0]     trans_size_i;
  logic              ready_start_o, done_o;
  logic [NB-1:0]     tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [NB*32-1:0]  tcdm_add_o, tcdm_data_o, tcdm_r_data_i, stream_data_o;
  logic [NB*4-1:0]   tcdm_be_o, stream_strb_o;
  logic              stream_valid_o, stream_ready_i;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_reader #(.NB_TCDM_PORTS(NB), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .trans_size_i(trans_size_i),
    .ready_start_o(ready_start_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  // reference model state
  bit working, done_exp;
  int granted[NB], arrived[NB], bo, m_size;
  logic [31:0] m_base;
  logic [15:0] m_stride;
  // memory responder state (one-cycle latency)
  bit resp_pend[NB], resp_cnt[NB];
  logic [31:0] resp_addr[NB];
  // stimulus policies
  int gnt_mode = 0, rdy_mode = 0, hold1 = 0, rdy_hold = 0;
  bit stale_inject = 1'b0, stalled_once = 1'b0, start_noise = 1'b0;
  int start_cyc, first_valid_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] exp_addr(input int lane, input int j);
    return m_base + 32'(j) * {16'h0000, m_stride} + 32'(4 * lane);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    working = 1'b0; done_exp = 1'b0; bo = 0;
    for (int i = 0; i < NB; i++) begin
      granted[i] = 0; arrived[i] = 0; resp_cnt[i] = 1'b0;
    end
  endtask

  task automatic tick();
    bit req_e[NB];
    bit v_e, hs, was_working, g;
    @(negedge clk_i);
    for (int i = 0; i < NB; i++) begin
      tcdm_r_valid_i[i]         = resp_pend[i] | stale_inject;
      tcdm_r_data_i[32*i +: 32] = resp_pend[i] ? mem_word(resp_addr[i]) : 32'hDEAD_BEEF;
      tcdm_gnt_i[i]             = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    if (hold1 > 0) begin tcdm_gnt_i[1] = 1'b0; hold1--; end
    if (rdy_hold > 0) begin stream_ready_i = 1'b0; rdy_hold--; end
    else stream_ready_i = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (start_noise && working) start_i = 1'($urandom_range(0, 1));
    #1;
    v_e = (arrived[0] > bo) && (arrived[1] > bo);
    chk("ready_start", ready_start_o, !working);
    chk("done", done_o, done_exp);
    chk("stream_valid", stream_valid_o, v_e);
    if (v_e) chk("stream_data", stream_data_o, {mem_word(exp_addr(1, bo)), mem_word(exp_addr(0, bo))});
    chk("const_outs", {tcdm_wen_o, stream_strb_o, tcdm_data_o != '0}, {2'b11, 8'hFF, 1'b0});
    for (int i = 0; i < NB; i++) begin
      req_e[i] = working && (granted[i] < m_size) && ((granted[i] - bo) < DEPTH);
      chk($sformatf("req%0d", i), tcdm_req_o[i], req_e[i]);
      chk($sformatf("be%0d", i), tcdm_be_o[4*i +: 4], req_e[i] ? 4'hF : 4'h0);
      if (req_e[i]) chk($sformatf("addr%0d", i), tcdm_add_o[32*i +: 32], exp_addr(i, granted[i]));
    end
    if (stream_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    was_working = working;
    done_exp = 1'b0;
    for (int i = 0; i < NB; i++) if (resp_cnt[i]) arrived[i]++;
    hs = v_e && stream_ready_i;
    for (int i = 0; i < NB; i++) begin
      g            = req_e[i] && tcdm_gnt_i[i] && !clear_i;
      resp_pend[i] = tcdm_req_o[i] & tcdm_gnt_i[i];
      resp_addr[i] = tcdm_add_o[32*i +: 32];
      resp_cnt[i]  = g;
      if (g) granted[i]++;
    end
    if (clear_i) model_reset();
    else begin
      if (hs) begin
        bo++;
        if (bo == m_size) begin working = 1'b0; done_exp = 1'b1; end
        if (rdy_mode == 2 && !stalled_once) begin rdy_hold = 10; stalled_once = 1'b1; end
      end
      if (!was_working && start_i) begin
        m_base = base_addr_i; m_stride = stride_i; m_size = int'(trans_size_i); bo = 0;
        for (int i = 0; i < NB; i++) begin granted[i] = 0; arrived[i] = 0; end
        if (m_size == 0) done_exp = 1'b1;
        else working = 1'b1;
      end
    end
    stale_inject = 1'b0;
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_xfer(input logic [31:0] b, input logic [15:0] s, input int n);
    int guard;
    base_addr_i = b; stride_i = s; trans_size_i = CW'(n); start_i = 1'b1;
    start_cyc = cyc; first_valid_cyc = -1;
    tick();
    start_i = 1'b0;
    guard = 0;
    while (working && guard < 2000) begin tick(); guard++; end
    chk("xfer_timeout", guard < 2000, 1'b1);
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    int guard;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = 32'h0; stride_i = 16'h0; trans_size_i = '0;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0; stream_ready_i = 1'b0;
    for (int i = 0; i < NB; i++) begin resp_pend[i] = 1'b0; resp_addr[i] = 32'h0; end
    model_reset();
    tick(); tick();
    @(negedge clk_i); rst_ni = 1'b1;
    tick();

    // basic transfer with fixed latency
    run_xfer(32'h0000_1000, 16'd8, 4);
    chk("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd3);

    // backpressure: ready low for 10 cycles after the first beat
    rdy_mode = 2; stalled_once = 1'b0;
    run_xfer(32'h0000_2000, 16'd4, 12);
    rdy_mode = 0;

    // skewed grants on lane 1
    hold1 = 5;
    run_xfer(32'h0000_3000, 16'd12, 6);

    // zero-length transfer
    run_xfer(32'h0000_4000, 16'd4, 0);

    // address wrap modulo 2^32
    run_xfer(32'hFFFF_FFF0, 16'hFFFC, 5);

    // randomized grants, ready and spurious start during work
    gnt_mode = 1; rdy_mode = 1; start_noise = 1'b1;
    for (int k = 0; k < 6; k++)
      run_xfer($urandom & 32'hFFFF_FFFC, 16'($urandom), $urandom_range(1, 12));
    gnt_mode = 0; rdy_mode = 0; start_noise = 1'b0;

    // mid-transfer clear, late response dropped, then restart
    base_addr_i = 32'h0000_5000; stride_i = 16'd8; trans_size_i = CW'(8); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    guard = 0;
    while (bo < 2 && guard < 200) begin tick(); guard++; end
    chk("clear_reach", guard < 200, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    stale_inject = 1'b1;
    tick(); tick(); tick();
    chk("after_clear_valid", stream_valid_o, 1'b0);
    run_xfer(32'h0000_6000, 16'd4, 2);

    // asynchronous reset mid-transfer
    base_addr_i = 32'h0000_7000; stride_i = 16'd8; trans_size_i = CW'(10); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_req", tcdm_req_o, 2'b00);
    chk("rst_add", tcdm_add_o, 64'h0);
    chk("rst_be", tcdm_be_o, 8'h00);
    chk("rst_valid", stream_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ready_start", ready_start_o, 1'b1);
    model_reset();
    for (int i = 0; i < NB; i++) resp_pend[i] = 1'b0;
    tick();
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    run_xfer(32'h0000_8000, 16'd16, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
